// File: rtl/zx_kbd_pkg.sv
// Shared constants, receiver states and the PS/2 set-2 to ZX Spectrum key map.
// Define ZXKBD_COMPOUND_EN to map Backspace and the arrow keys to CapsShift+digit.
package zx_kbd_pkg;

  localparam logic [7:0] PS2_RELEASE = 8'hF0;
  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;
  localparam int         PAUSE_SKIP  = 7;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {
    KEY_NONE, KEY_MATRIX, KEY_SYM_RSHIFT, KEY_SYM_LCTRL, KEY_COMPOUND
  } key_kind_e;

  // For KEY_COMPOUND, col carries the compound-vector index.
  typedef struct packed {
    key_kind_e  kind;
    logic [2:0] row;
    logic [2:0] col;
  } key_loc_t;

  localparam logic [2:0] CAPS_ROW = 3'd0;
  localparam logic [2:0] CAPS_COL = 3'd0;
  localparam logic [2:0] SYM_ROW  = 3'd7;
  localparam logic [2:0] SYM_COL  = 3'd1;

  localparam logic [2:0] COMP_BKSP  = 3'd0;
  localparam logic [2:0] COMP_LEFT  = 3'd1;
  localparam logic [2:0] COMP_DOWN  = 3'd2;
  localparam logic [2:0] COMP_UP    = 3'd3;
  localparam logic [2:0] COMP_RIGHT = 3'd4;

  // Digit position {row,col} pressed by each compound bit: 8, 7, 6, 5, 0.
  localparam logic [4:0][5:0] COMP_DIGIT = {6'o42, 6'o43, 6'o44, 6'o34, 6'o40};

  function automatic key_loc_t mk(input logic [2:0] row, input logic [2:0] col);
    return '{kind: KEY_MATRIX, row: row, col: col};
  endfunction

  function automatic key_loc_t mk_comp(input logic [2:0] idx);
    return '{kind: KEY_COMPOUND, row: 3'd0, col: idx};
  endfunction

  function automatic key_loc_t key_lookup(input logic ext, input logic [7:0] code);
    key_loc_t loc;
    loc = '{kind: KEY_NONE, row: 3'd0, col: 3'd0};
    if (!ext) begin
      case (code)
        8'h12: loc = mk(3'd0, 3'd0);  8'h1A: loc = mk(3'd0, 3'd1);
        8'h22: loc = mk(3'd0, 3'd2);  8'h21: loc = mk(3'd0, 3'd3);
        8'h2A: loc = mk(3'd0, 3'd4);
        8'h1C: loc = mk(3'd1, 3'd0);  8'h1B: loc = mk(3'd1, 3'd1);
        8'h23: loc = mk(3'd1, 3'd2);  8'h2B: loc = mk(3'd1, 3'd3);
        8'h34: loc = mk(3'd1, 3'd4);
        8'h15: loc = mk(3'd2, 3'd0);  8'h1D: loc = mk(3'd2, 3'd1);
        8'h24: loc = mk(3'd2, 3'd2);  8'h2D: loc = mk(3'd2, 3'd3);
        8'h2C: loc = mk(3'd2, 3'd4);
        8'h16: loc = mk(3'd3, 3'd0);  8'h1E: loc = mk(3'd3, 3'd1);
        8'h26: loc = mk(3'd3, 3'd2);  8'h25: loc = mk(3'd3, 3'd3);
        8'h2E: loc = mk(3'd3, 3'd4);
        8'h45: loc = mk(3'd4, 3'd0);  8'h46: loc = mk(3'd4, 3'd1);
        8'h3E: loc = mk(3'd4, 3'd2);  8'h3D: loc = mk(3'd4, 3'd3);
        8'h36: loc = mk(3'd4, 3'd4);
        8'h4D: loc = mk(3'd5, 3'd0);  8'h44: loc = mk(3'd5, 3'd1);
        8'h43: loc = mk(3'd5, 3'd2);  8'h3C: loc = mk(3'd5, 3'd3);
        8'h35: loc = mk(3'd5, 3'd4);
        8'h5A: loc = mk(3'd6, 3'd0);  8'h4B: loc = mk(3'd6, 3'd1);
        8'h42: loc = mk(3'd6, 3'd2);  8'h3B: loc = mk(3'd6, 3'd3);
        8'h33: loc = mk(3'd6, 3'd4);
        8'h29: loc = mk(3'd7, 3'd0);  8'h3A: loc = mk(3'd7, 3'd2);
        8'h31: loc = mk(3'd7, 3'd3);  8'h32: loc = mk(3'd7, 3'd4);
        8'h59: loc.kind = KEY_SYM_RSHIFT;
        8'h14: loc.kind = KEY_SYM_LCTRL;
`ifdef ZXKBD_COMPOUND_EN
        8'h66: loc = mk_comp(COMP_BKSP);
`endif
        default: ;
      endcase
    end else begin
`ifdef ZXKBD_COMPOUND_EN
      case (code)
        8'h6B:   loc = mk_comp(COMP_LEFT);
        8'h72:   loc = mk_comp(COMP_DOWN);
        8'h75:   loc = mk_comp(COMP_UP);
        8'h74:   loc = mk_comp(COMP_RIGHT);
        default: ;
      endcase
`endif
    end
    return loc;
  endfunction

endpackage

// File: rtl/zx_keyboard_port_ps2_rx.sv
// PS/2 device-to-host receiver: line synchroniser, 11-bit frame FSM and
// inactivity timeout; emits one-cycle byte_valid or error pulses.
module ps2_rx
  import zx_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, clk_s, dat_s, fall;
  rx_state_e              state, state_next;
  logic [2:0]             bit_cnt;
  logic                   parity_ok;
  logic [TW-1:0]          timer;
  logic                   timeout, valid_next, error_next;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_prev & ~clk_s;
  assign timeout = (state != RX_IDLE) && (timer == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      byte_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      byte_valid <= valid_next;
      error      <= error_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    error_next = 1'b0;
    if (timeout) begin
      state_next = RX_IDLE;
      error_next = 1'b1;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!dat_s) state_next = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
        RX_PARITY: state_next = RX_STOP;
        RX_STOP: begin
          state_next = RX_IDLE;
          if (dat_s && parity_ok) valid_next = 1'b1;
          else                    error_next = 1'b1;
        end
        default:   state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      data      <= '0;
      parity_ok <= 1'b0;
      timer     <= '0;
    end else begin
      timer <= (fall || state == RX_IDLE) ? '0 : timer + 1'b1;
      if (fall) begin
        case (state)
          RX_IDLE:   bit_cnt <= '0;
          RX_DATA: begin
            data    <= {dat_s, data[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          RX_PARITY: parity_ok <= ^{data, dat_s};
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/zx_keyboard_port.sv
// ZX Spectrum port FE read side: PS/2 scancode decoder, 8x5 key matrix and
// half-row mux. Compound keys are enabled by ZXKBD_COMPOUND_EN (see package).
module zx_keyboard_port
  import zx_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic [15:0] A,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        ear_in,
  output logic [7:0]  q,
  output logic        oe,
  output logic        kbd_error
);

  logic             byte_valid;
  logic [7:0]       rx_data;
  logic [7:0][4:0]  matrix, eff;
  logic [1:0]       sym_n;
  logic [4:0]       comp;
  logic             rel_flag, ext_flag;
  logic [2:0]       skip_cnt;
  key_loc_t         loc;
  logic [4:0]       row_data;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(byte_valid),
    .data      (rx_data),
    .error     (kbd_error)
  );

  assign loc = key_lookup(ext_flag, rx_data);

  // Matrix is active-low (1 = released); SymShift sources and compound
  // keys live outside it so releasing one never masks another.
  // NOTE: the matrix is a small flop array, so resetting it is cheap and
  // guarantees "all released" after reset; large RAMs would not be reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix   <= '1;
      sym_n    <= 2'b11;
      comp     <= '0;
      rel_flag <= 1'b0;
      ext_flag <= 1'b0;
      skip_cnt <= '0;
    end else if (byte_valid) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 1'b1;
      end else if (rx_data == PS2_RELEASE) begin
        rel_flag <= 1'b1;
      end else if (rx_data == PS2_EXT) begin
        ext_flag <= 1'b1;
      end else if (rx_data == PS2_PAUSE) begin
        skip_cnt <= 3'(PAUSE_SKIP);
        rel_flag <= 1'b0;
        ext_flag <= 1'b0;
      end else begin
        case (loc.kind)
          KEY_MATRIX:     matrix[loc.row][loc.col] <= rel_flag;
          KEY_SYM_RSHIFT: sym_n[0]                 <= rel_flag;
          KEY_SYM_LCTRL:  sym_n[1]                 <= rel_flag;
          KEY_COMPOUND:   comp[loc.col]            <= ~rel_flag;
          default:        ;
        endcase
        rel_flag <= 1'b0;
        ext_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    eff                     = matrix;
    eff[SYM_ROW][SYM_COL]   = &sym_n;
    eff[CAPS_ROW][CAPS_COL] = matrix[CAPS_ROW][CAPS_COL] & ~(|comp);
    for (int i = 0; i < 5; i++)
      eff[COMP_DIGIT[i][5:3]][COMP_DIGIT[i][2:0]] =
        eff[COMP_DIGIT[i][5:3]][COMP_DIGIT[i][2:0]] & ~comp[i];
  end

  always_comb begin
    row_data = '1;
    for (int r = 0; r < 8; r++)
      if (!A[8+r]) row_data = row_data & eff[r];
  end

  assign oe = !nIORQ && !nRD && !A[0];

  // Registered every cycle, so a same-cycle matrix update appears one clock later.
  always_ff @(posedge clk) begin
    if (reset) q <= 8'hFF;
    else       q <= {1'b1, ear_in, 1'b1, row_data};
  end

endmodule

// File: tb/tb_zx_keyboard_port.sv
// Self-checking bench for zx_keyboard_port: directed scenarios plus random
// key traffic against a held-key-set reference model.
module tb_zx_keyboard_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] A = 16'hFFFF;
  logic        nIORQ = 1'b1;
  logic        nRD = 1'b1;
  logic        ear_in = 1'b0;
  logic [7:0]  q;
  logic        oe;
  logic        kbd_error;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;

  bit [255:0] held_n, held_e;

  logic [7:0] keymap [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h59, 8'h3A, 8'h31, 8'h32};

  zx_keyboard_port dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .A(A), .nIORQ(nIORQ), .nRD(nRD), .ear_in(ear_in),
    .q(q), .oe(oe), .kbd_error(kbd_error));

  always #20 clk = ~clk;

  always @(posedge clk) if (kbd_error === 1'b1) err_seen++;

  // Reference model: set of held keys -> pressed positions (row*5+col).
  function automatic logic [4:0] model_rows(input logic [7:0] ah);
    bit [39:0]  p;
    logic [4:0] r;
    p = '0;
    for (int k = 0; k < 40; k++) if (held_n[keymap[k]]) p[k] = 1'b1;
    if (held_n[8'h14]) p[36] = 1'b1;
`ifdef ZXKBD_COMPOUND_EN
    if (held_n[8'h66]) begin p[0] = 1'b1; p[20] = 1'b1; end
    if (held_e[8'h6B]) begin p[0] = 1'b1; p[19] = 1'b1; end
    if (held_e[8'h72]) begin p[0] = 1'b1; p[24] = 1'b1; end
    if (held_e[8'h75]) begin p[0] = 1'b1; p[23] = 1'b1; end
    if (held_e[8'h74]) begin p[0] = 1'b1; p[22] = 1'b1; end
`endif
    r = 5'h1F;
    for (int row = 0; row < 8; row++)
      if (!ah[row])
        for (int c = 0; c < 5; c++) if (p[row*5+c]) r[c] = 1'b0;
    return r;
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic ps2_send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic key_event(input logic ext, input logic [7:0] code, input logic rel);
    if (ext) ps2_send(8'hE0, 1'b0, 1'b0);
    if (rel) ps2_send(8'hF0, 1'b0, 1'b0);
    ps2_send(code, 1'b0, 1'b0);
    if (ext) held_e[code] = !rel;
    else     held_n[code] = !rel;
  endtask

  // Address changes at a falling edge; q is sampled one rising edge later.
  task automatic do_read(input logic [15:0] addr, input logic ear,
                         output logic [7:0] qv, output logic oev);
    @(negedge clk);
    A = addr; ear_in = ear; nIORQ = 1'b0; nRD = 1'b0;
    @(negedge clk);
    qv = q; oev = oe;
    nIORQ = 1'b1; nRD = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] qv; logic oev;
    repeat (3) @(negedge clk);
    n_checks++; if (q !== 8'hFF) $display("FAIL reset_q got=%h exp=ff", q); else n_pass++;
    n_checks++; if (kbd_error !== 1'b0) $display("FAIL reset_err got=%b exp=0", kbd_error); else n_pass++;
    n_checks++; if (oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", oe); else n_pass++;
    reset = 1'b0;
    do_read(16'h00FE, 1'b1, qv, oev);
    n_checks++; if (qv !== 8'hFF) $display("FAIL idle_read got=%h exp=ff", qv); else n_pass++;
    n_checks++; if (oev !== 1'b1) $display("FAIL idle_oe got=%b exp=1", oev); else n_pass++;
  endtask

  task automatic test_press_release;
    logic [7:0] qv; logic oev;
    key_event(1'b0, 8'h1C, 1'b0);
    do_read(16'hFDFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL a_held got=%h exp=be", qv); else n_pass++;
    key_event(1'b0, 8'h1C, 1'b1);
    do_read(16'hFDFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBF) $display("FAIL a_released got=%h exp=bf", qv); else n_pass++;
  endtask

  task automatic test_multi_row;
    logic [7:0] qv; logic oev;
    key_event(1'b0, 8'h1A, 1'b0);
    key_event(1'b0, 8'h29, 1'b0);
    do_read(16'h00FE, 1'b0, qv, oev);
    n_checks++; if (qv[4:0] !== 5'h1C) $display("FAIL all_rows got=%h exp=1c", qv[4:0]); else n_pass++;
    do_read(16'hFEFE, 1'b0, qv, oev);
    n_checks++; if (qv[4:0] !== 5'h1D) $display("FAIL row_a8 got=%h exp=1d", qv[4:0]); else n_pass++;
    do_read(16'h7FFE, 1'b0, qv, oev);
    n_checks++; if (qv[4:0] !== 5'h1E) $display("FAIL row_a15 got=%h exp=1e", qv[4:0]); else n_pass++;
    key_event(1'b0, 8'h1A, 1'b1);
    key_event(1'b0, 8'h29, 1'b1);
  endtask

  task automatic test_frame_errors;
    logic [7:0] qv; logic oev; int e0;
    e0 = err_seen;
    ps2_send(8'h1C, 1'b1, 1'b0);
    n_checks++; if (err_seen - e0 !== 1) $display("FAIL parity_err pulses=%0d exp=1", err_seen - e0); else n_pass++;
    do_read(16'hFDFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBF) $display("FAIL parity_nochange got=%h exp=bf", qv); else n_pass++;
    e0 = err_seen;
    ps2_send(8'h1C, 1'b0, 1'b1);
    n_checks++; if (err_seen - e0 !== 1) $display("FAIL stop_err pulses=%0d exp=1", err_seen - e0); else n_pass++;
    do_read(16'hFDFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBF) $display("FAIL stop_nochange got=%h exp=bf", qv); else n_pass++;
    // A falling edge with data high is a false start and is ignored.
    e0 = err_seen;
    ps2_bit(1'b1);
    key_event(1'b0, 8'h1C, 1'b0);
    n_checks++; if (err_seen - e0 !== 0) $display("FAIL false_start_err pulses=%0d exp=0", err_seen - e0); else n_pass++;
    do_read(16'hFDFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL after_false_start got=%h exp=be", qv); else n_pass++;
    key_event(1'b0, 8'h1C, 1'b1);
  endtask

  task automatic test_timeout;
    logic [7:0] qv; logic oev; int e0;
    e0 = err_seen;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (30000) @(negedge clk);
    n_checks++; if (err_seen - e0 !== 1) $display("FAIL timeout_err pulses=%0d exp=1", err_seen - e0); else n_pass++;
    key_event(1'b0, 8'h15, 1'b0);
    do_read(16'hFBFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL after_timeout got=%h exp=be", qv); else n_pass++;
    key_event(1'b0, 8'h15, 1'b1);
  endtask

  task automatic test_pause;
    logic [7:0] qv; logic oev; int e0;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    e0 = err_seen;
    for (int i = 0; i < 8; i++) ps2_send(seq[i], 1'b0, 1'b0);
    do_read(16'h7FFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBF) $display("FAIL pause_skipped got=%h exp=bf", qv); else n_pass++;
    key_event(1'b0, 8'h29, 1'b0);
    do_read(16'h7FFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL after_pause got=%h exp=be", qv); else n_pass++;
    n_checks++; if (err_seen - e0 !== 0) $display("FAIL pause_err pulses=%0d exp=0", err_seen - e0); else n_pass++;
    key_event(1'b0, 8'h29, 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] qv, code; logic oev, ext, ear; logic [15:0] addr; int idx;
    for (int it = 0; it < 12; it++) begin
      idx = $urandom_range(0, 42);
      ext = (idx == 42);
      code = (idx < 40) ? keymap[idx] : (idx == 40) ? 8'h14 : (idx == 41) ? 8'h76 : 8'h1C;
      key_event(ext, code, ext ? held_e[code] : held_n[code]);
      for (int k = 0; k < 2; k++) begin
        addr = {8'($urandom), 7'h7F, 1'($urandom_range(0, 1))};
        ear = 1'($urandom);
        do_read(addr, ear, qv, oev);
        n_checks++;
        if (qv !== {1'b1, ear, 1'b1, model_rows(addr[15:8])})
          $display("FAIL random_q addr=%h got=%h exp=%h", addr, qv,
                   {1'b1, ear, 1'b1, model_rows(addr[15:8])});
        else n_pass++;
        n_checks++;
        if (oev !== ~addr[0]) $display("FAIL random_oe addr=%h got=%b exp=%b", addr, oev, ~addr[0]);
        else n_pass++;
      end
    end
    for (int c = 0; c < 256; c++) begin
      if (held_n[c]) key_event(1'b0, 8'(c), 1'b1);
      if (held_e[c]) key_event(1'b1, 8'(c), 1'b1);
    end
  endtask

  task automatic test_compound;
    logic [7:0] qv; logic oev;
`ifdef ZXKBD_COMPOUND_EN
    key_event(1'b0, 8'h12, 1'b0);
    key_event(1'b1, 8'h75, 1'b0);
    do_read(16'hFEFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL up_caps got=%h exp=be", qv); else n_pass++;
    do_read(16'hEFFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hB7) $display("FAIL up_digit7 got=%h exp=b7", qv); else n_pass++;
    key_event(1'b1, 8'h75, 1'b1);
    do_read(16'hFEFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL lshift_kept got=%h exp=be", qv); else n_pass++;
    do_read(16'hEFFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBF) $display("FAIL up_released got=%h exp=bf", qv); else n_pass++;
    key_event(1'b0, 8'h12, 1'b1);
    key_event(1'b0, 8'h66, 1'b0);
    do_read(16'hEEFE, 1'b0, qv, oev);
    n_checks++; if (qv[4:0] !== 5'h1E) $display("FAIL bksp got=%h exp=1e", qv[4:0]); else n_pass++;
    key_event(1'b0, 8'h66, 1'b1);
    do_read(16'hEEFE, 1'b0, qv, oev);
    n_checks++; if (qv[4:0] !== 5'h1F) $display("FAIL bksp_rel got=%h exp=1f", qv[4:0]); else n_pass++;
`else
    key_event(1'b1, 8'h75, 1'b0);
    do_read(16'h00FE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBF) $display("FAIL arrow_unmapped got=%h exp=bf", qv); else n_pass++;
    key_event(1'b1, 8'h75, 1'b1);
    // Flags must be clear: a plain 1C afterwards is a press of A.
    key_event(1'b0, 8'h1C, 1'b0);
    do_read(16'hFDFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBE) $display("FAIL flags_cleared got=%h exp=be", qv); else n_pass++;
    key_event(1'b0, 8'h1C, 1'b1);
`endif
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] qv; logic oev; int e0;
    key_event(1'b0, 8'h1A, 1'b0);
    key_event(1'b0, 8'h1C, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (q !== 8'hFF) $display("FAIL midreset_q got=%h exp=ff", q); else n_pass++;
    reset = 1'b0;
    held_n = '0; held_e = '0;
    e0 = err_seen;
    do_read(16'h00FE, 1'b1, qv, oev);
    n_checks++; if (qv !== 8'hFF) $display("FAIL released_after_reset got=%h exp=ff", qv); else n_pass++;
    @(negedge clk);
    A = 16'h00FE; nIORQ = 1'b1; nRD = 1'b0;
    @(negedge clk);
    n_checks++; if (oe !== 1'b0) $display("FAIL oe_no_iorq got=%b exp=0", oe); else n_pass++;
    nRD = 1'b1;
    key_event(1'b0, 8'h1A, 1'b0);
    do_read(16'hFEFE, 1'b0, qv, oev);
    n_checks++; if (qv !== 8'hBD) $display("FAIL rx_after_reset got=%h exp=bd", qv); else n_pass++;
    n_checks++; if (err_seen - e0 !== 0) $display("FAIL midreset_err pulses=%0d exp=0", err_seen - e0); else n_pass++;
  endtask

  initial begin
    held_n = '0; held_e = '0;
    test_reset();
    test_press_release();
    test_multi_row();
    test_frame_errors();
    test_timeout();
    test_pause();
    test_random();
    test_compound();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
